// File: rtl/ovl_time_window_gen_pkg.sv
// Shared constants and types for the time-window generator: new-start policy
// codes, FSM state encoding and the window counter operation codes.
package ovl_time_window_gen_pkg;

  localparam int unsigned OVL_IGNORE_NEW_START   = 0;
  localparam int unsigned OVL_RESET_ON_NEW_START = 1;
  localparam int unsigned OVL_ERROR_ON_NEW_START = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_t;

  function automatic bit policy_is_valid(int unsigned policy);
    return policy <= OVL_ERROR_ON_NEW_START;
  endfunction

endpackage

// File: rtl/ovl_time_window_gen_if.sv
// Bundle of the window generator's data-path signals; the checker-side driver
// uses master, the generator itself uses slave.
interface ovl_time_window_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             enable;
  logic             start_event;
  logic             test_expr;
  logic             xzcheck_enable;
  logic             window;
  logic             window_close;
  logic [CNT_W-1:0] remaining;
  logic             fire_assert;
  logic             fire_new_start;
  logic             fire_xz;
  logic             cov_window_open;
  logic             cov_window_reset;

  modport master (
    output enable, start_event, test_expr, xzcheck_enable,
    input  window, window_close, remaining,
           fire_assert, fire_new_start, fire_xz,
           cov_window_open, cov_window_reset
  );

  modport slave (
    input  enable, start_event, test_expr, xzcheck_enable,
    output window, window_close, remaining,
           fire_assert, fire_new_start, fire_xz,
           cov_window_open, cov_window_reset
  );
endinterface

// File: rtl/ovl_window_counter.sv
// Loadable saturating down-counter holding the number of window cycles left.
// Decrement stops at zero so an idle counter never wraps.
module ovl_window_counter
  import ovl_time_window_gen_pkg::*;
#(
  parameter int unsigned NUM_CKS = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  cnt_op_t          op,
  output logic [CNT_W-1:0] remaining,
  output logic             is_last
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(NUM_CKS);

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
    end else begin
      case (op)
        CNT_LOAD: remaining <= LOAD_VAL;
        CNT_DEC:  if (remaining != '0) remaining <= remaining - CNT_W'(1);
        default:  remaining <= remaining;
      endcase
    end
  end

  assign is_last = (remaining == CNT_W'(1));

endmodule

// File: rtl/ovl_time_window_gen.sv
// Window generator for the time-checker vunits: opens a NUM_CKS-cycle window on
// start_event, applies the new-start policy and emits registered fire/cover pulses.
module ovl_time_window_gen
  import ovl_time_window_gen_pkg::*;
#(
  parameter int unsigned NUM_CKS             = 2,
  parameter int unsigned ACTION_ON_NEW_START = 0,
  parameter int unsigned CNT_W               = 16
) (
  input logic                 clk,
  input logic                 reset,
  ovl_time_window_gen_if.slave bus
);

  if (!policy_is_valid(ACTION_ON_NEW_START)) begin : g_bad_policy
    $error("ovl_time_window_gen: ACTION_ON_NEW_START must be 0, 1 or 2");
  end
  if (NUM_CKS < 1 || NUM_CKS > 65535) begin : g_bad_num_cks
    $error("ovl_time_window_gen: NUM_CKS must be in 1..65535");
  end
  if ((64'd1 << CNT_W) <= 64'(NUM_CKS)) begin : g_bad_cnt_w
    $error("ovl_time_window_gen: CNT_W too narrow for NUM_CKS");
  end

  localparam bit POLICY_RESET = (ACTION_ON_NEW_START == OVL_RESET_ON_NEW_START);
  localparam bit POLICY_ERROR = (ACTION_ON_NEW_START == OVL_ERROR_ON_NEW_START);

  state_t           state, state_nxt;
  cnt_op_t          cnt_op;
  logic [CNT_W-1:0] remaining;
  logic             is_last;

  logic fire_assert_d, fire_new_start_d, fire_xz_d, cov_open_d, cov_reset_d;
  logic fire_assert_q, fire_new_start_q, fire_xz_q, cov_open_q, cov_reset_q;

  ovl_window_counter #(
    .NUM_CKS (NUM_CKS),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .op        (cnt_op),
    .remaining (remaining),
    .is_last   (is_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Conditions are written as if-tests so an X on start_event falls to the
  // no-start branch instead of propagating into the state or counter.
  always_comb begin
    state_nxt = state;
    cnt_op    = CNT_HOLD;
    if (bus.enable) begin
      case (state)
        IDLE: begin
          if (bus.start_event) begin
            state_nxt = OPEN;
            cnt_op    = CNT_LOAD;
          end
        end
        OPEN: begin
          if (is_last) begin
            if (bus.start_event) begin
              cnt_op = CNT_LOAD;
            end else begin
              state_nxt = IDLE;
              cnt_op    = CNT_DEC;
            end
          end else if (bus.start_event && POLICY_RESET) begin
            cnt_op = CNT_LOAD;
          end else begin
            cnt_op = CNT_DEC;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fire_assert_d    = 1'b0;
    fire_new_start_d = 1'b0;
    fire_xz_d        = 1'b0;
    cov_open_d       = 1'b0;
    cov_reset_d      = 1'b0;
    if (bus.enable) begin
      if (state == OPEN && !bus.test_expr) fire_assert_d = 1'b1;
      if (bus.start_event) begin
        if (state == IDLE || is_last) cov_open_d       = 1'b1;
        else if (POLICY_RESET)        cov_reset_d      = 1'b1;
        else if (POLICY_ERROR)        fire_new_start_d = 1'b1;
      end
`ifndef SYNTHESIS
      if (bus.xzcheck_enable && $isunknown({bus.start_event, bus.test_expr}))
        fire_xz_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_assert_q    <= 1'b0;
      fire_new_start_q <= 1'b0;
      fire_xz_q        <= 1'b0;
      cov_open_q       <= 1'b0;
      cov_reset_q      <= 1'b0;
    end else begin
      fire_assert_q    <= fire_assert_d;
      fire_new_start_q <= fire_new_start_d;
      fire_xz_q        <= fire_xz_d;
      cov_open_q       <= cov_open_d;
      cov_reset_q      <= cov_reset_d;
    end
  end

  assign bus.window           = (state == OPEN);
  assign bus.window_close     = (state == OPEN) && is_last;
  assign bus.remaining        = remaining;
  assign bus.fire_assert      = fire_assert_q;
  assign bus.fire_new_start   = fire_new_start_q;
  assign bus.fire_xz          = fire_xz_q;
  assign bus.cov_window_open  = cov_open_q;
  assign bus.cov_window_reset = cov_reset_q;

endmodule

// File: tb/tb_ovl_time_window_gen.sv
// Randomized bench: four generator configurations share one stimulus stream and
// are compared each cycle against a window-end-time reference model.
module tb_ovl_time_window_gen;

  localparam int NI = 4;
  localparam int CW = 16;

  function automatic int unsigned cfg_n(int g);
    case (g)
      0: return 3;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned cfg_p(int g);
    case (g)
      0: return 0;
      1: return 1;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, start_event, test_expr, xzcheck_enable;

  logic [NI-1:0] o_win, o_close, o_fa, o_fns, o_fxz, o_cov, o_cr;
  logic [CW-1:0] o_rem [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ovl_time_window_gen_if #(.CNT_W(CW)) bus ();
    assign bus.enable         = enable;
    assign bus.start_event    = start_event;
    assign bus.test_expr      = test_expr;
    assign bus.xzcheck_enable = xzcheck_enable;

    ovl_time_window_gen #(
      .NUM_CKS             (cfg_n(g)),
      .ACTION_ON_NEW_START (cfg_p(g)),
      .CNT_W               (CW)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign o_win[g]   = bus.window;
    assign o_close[g] = bus.window_close;
    assign o_rem[g]   = bus.remaining;
    assign o_fa[g]    = bus.fire_assert;
    assign o_fns[g]   = bus.fire_new_start;
    assign o_fxz[g]   = bus.fire_xz;
    assign o_cov[g]   = bus.cov_window_open;
    assign o_cr[g]    = bus.cov_window_reset;
  end

  // Model: a window is described by whether it is open and the cycle index of
  // its last cycle; everything else is derived arithmetically from those.
  bit m_open [NI];
  int m_close_at [NI];
  bit m_fa [NI], m_fns [NI], m_fxz [NI], m_cov [NI], m_cr [NI];
  int cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  task automatic model_edge(input int g);
    int unsigned n;
    bit last;
    n = cfg_n(g);
    m_fa[g] = 0; m_fns[g] = 0; m_fxz[g] = 0; m_cov[g] = 0; m_cr[g] = 0;
    if (reset === 1'b1) begin
      m_open[g] = 0;
    end else if (enable !== 1'b1) begin
      if (m_open[g]) m_close_at[g]++;
    end else begin
      last = m_open[g] && (m_close_at[g] == cyc);
      if (m_open[g] && test_expr === 1'b0) m_fa[g] = 1;
      if (xzcheck_enable === 1'b1 && $isunknown(start_event ^ test_expr)) m_fxz[g] = 1;
      if (start_event === 1'b1) begin
        if (!m_open[g] || last) begin
          m_open[g] = 1; m_close_at[g] = cyc + int'(n); m_cov[g] = 1;
        end else if (cfg_p(g) == 1) begin
          m_close_at[g] = cyc + int'(n); m_cr[g] = 1;
        end else if (cfg_p(g) == 2) begin
          m_fns[g] = 1;
        end
      end else if (last) begin
        m_open[g] = 0;
      end
    end
  endtask

  task automatic check_all();
    int exp_rem;
    for (int g = 0; g < NI; g++) begin
      exp_rem = m_open[g] ? (m_close_at[g] - cyc + 1) : 0;
      check_eq($sformatf("window[%0d]", g), 32'(o_win[g]), 32'(m_open[g]));
      check_eq($sformatf("window_close[%0d]", g), 32'(o_close[g]),
               32'(m_open[g] && m_close_at[g] == cyc));
      check_eq($sformatf("remaining[%0d]", g), 32'(o_rem[g]), 32'(exp_rem));
      check_eq($sformatf("fire_assert[%0d]", g), 32'(o_fa[g]), 32'(m_fa[g]));
      check_eq($sformatf("fire_new_start[%0d]", g), 32'(o_fns[g]), 32'(m_fns[g]));
      check_eq($sformatf("fire_xz[%0d]", g), 32'(o_fxz[g]), 32'(m_fxz[g]));
      check_eq($sformatf("cov_window_open[%0d]", g), 32'(o_cov[g]), 32'(m_cov[g]));
      check_eq($sformatf("cov_window_reset[%0d]", g), 32'(o_cr[g]), 32'(m_cr[g]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int g = 0; g < NI; g++) model_edge(g);
    cyc++;
    #1;
    check_all();
  endtask

  // Vector layout: {reset, enable, xzcheck_enable, start_event, test_expr}
  task automatic apply(input logic [4:0] v);
    {reset, enable, xzcheck_enable, start_event, test_expr} = v;
    step();
  endtask

  localparam int ND = 48;
  localparam logic [4:0] DIR [ND] = '{
    // single start, test_expr held high
    5'b01011, 5'b01001, 5'b01001, 5'b01001, 5'b01001, 5'b01001,
    // failing test_expr inside the window
    5'b01011, 5'b01001, 5'b01000, 5'b01001, 5'b01001, 5'b01001,
    // second start two cycles into the window
    5'b01011, 5'b01001, 5'b01011, 5'b01001, 5'b01001, 5'b01001, 5'b01001, 5'b01001,
    // start on the close cycle of the 3-cycle window
    5'b01011, 5'b01001, 5'b01001, 5'b01011, 5'b01001, 5'b01001, 5'b01001, 5'b01001,
    // reset mid-window with test_expr low
    5'b01011, 5'b01000, 5'b11000, 5'b01000, 5'b01001, 5'b01001,
    // enable low freezes the window even across a start
    5'b01011, 5'b00000, 5'b00010, 5'b00001, 5'b01001, 5'b01001, 5'b01001, 5'b01001,
    // back-to-back starts, one every cycle
    5'b01011, 5'b01011, 5'b01011, 5'b01001, 5'b01001, 5'b01001
  };

  initial begin
    {reset, enable, xzcheck_enable, start_event, test_expr} = 5'b10001;
    apply(5'b10001);
    apply(5'b10001);

    foreach (DIR[i]) apply(DIR[i]);

    // X/Z detection while every window is closed
    apply(5'b10001);
    {reset, enable, xzcheck_enable, start_event} = 4'b0110;
    test_expr = 1'bx;
    step();
    xzcheck_enable = 1'b0;
    step();
    apply(5'b01101);
    xzcheck_enable = 1'b1;
    start_event = 1'bx;
    step();
    apply(5'b01001);

    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(99) == 0);
      enable         = ($urandom_range(9) != 0);
      xzcheck_enable = $urandom_range(1);
      test_expr      = ($urandom_range(9) != 0);
      case ($urandom_range(49))
        0:       start_event = 1'bx;
        default: start_event = ($urandom_range(3) == 0);
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
